sop_sweep_ctrl: RTL and testbench

Sequencing controller for the 3-input canonical SOP function f(x1,x2,x3) = Σm(0,2,4,5,6). On a start request it drives the function's 3-bit input through all eight minterms in order 0..7. After a programmable settle time it samples the function output for each minterm and assembles the 8-entry truth table. It then compares the table against the expected minterm mask and reports pass/fail plus a mismatch count. It sits between the lab-board control logic (start/done) and the combinational SOP block, with an 8-bit status result.

---
 rtl/sop_sweep_ctrl.sv | 129 ++++++++++++
 tb/tb_sop_sweep_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sop_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sop_sweep_ctrl
// Description : Steps a 3-input SOP block through minterms 0..7, samples its
//               output after a settle delay and grades the truth table.
// Revision    : 1.0 - initial release
// ============================================================================
module sop_sweep_ctrl #(
    parameter logic [7:0] EXPECTED = 8'h75,
    parameter int         SETTLE   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [2:0] sop_in,
    input  logic       sop_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic       pass,
    output logic [3:0] mismatch_count
);

    localparam logic [3:0] c_settle = 4'(SETTLE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t     r_state;
    logic [2:0] r_idx;
    logic [3:0] r_cnt;
    logic [2:0] r_sop_in;
    logic       r_busy;
    logic       r_done;
    logic [7:0] r_result;
    logic       r_pass;
    logic [3:0] r_mismatch;

    logic [7:0] w_table;
    logic [7:0] w_diff;
    logic [3:0] w_mismatch;

    // Grade the table as it will look once the current sample lands.
    always_comb begin
        w_table        = r_result;
        w_table[r_idx] = sop_out;
        w_diff         = w_table ^ EXPECTED;
        w_mismatch     = 4'd0;
        for (int i = 0; i < 8; i++) begin
            w_mismatch = w_mismatch + {3'b000, w_diff[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_idx      <= 3'd0;
            r_cnt      <= 4'd0;
            r_sop_in   <= 3'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_result   <= 8'h00;
            r_pass     <= 1'b0;
            r_mismatch <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_sop_in <= 3'd0;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b0;
                    if (start) begin
                        r_state    <= ST_DRIVE;
                        r_idx      <= 3'd0;
                        r_cnt      <= 4'd0;
                        r_busy     <= 1'b1;
                        r_result   <= 8'h00;
                        r_pass     <= 1'b0;
                        r_mismatch <= 4'd0;
                    end
                end
                ST_DRIVE: begin
                    if (r_cnt != c_settle) begin
                        r_cnt <= r_cnt + 4'd1;
                    end else begin
                        r_result[r_idx] <= sop_out;
                        r_cnt           <= 4'd0;
                        if (r_idx == 3'd7) begin
                            r_state    <= ST_DONE;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_sop_in   <= 3'd0;
                            r_pass     <= (w_table == EXPECTED);
                            r_mismatch <= w_mismatch;
                        end else begin
                            r_idx    <= r_idx + 3'd1;
                            r_sop_in <= r_idx + 3'd1;
                        end
                    end
                end
                ST_DONE: begin
                    r_state  <= ST_IDLE;
                    r_done   <= 1'b0;
                    r_busy   <= 1'b0;
                    r_sop_in <= 3'd0;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_idx    <= 3'd0;
                    r_cnt    <= 4'd0;
                    r_sop_in <= 3'd0;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b0;
                end
            endcase
        end
    end

    assign sop_in         = r_sop_in;
    assign busy           = r_busy;
    assign done           = r_done;
    assign result         = r_result;
    assign pass           = r_pass;
    assign mismatch_count = r_mismatch;

endmodule
`default_nettype wire

// File: tb/tb_sop_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sop_sweep_ctrl
// Description : Self-checking bench for sop_sweep_ctrl (SETTLE=1 and SETTLE=0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sop_sweep_ctrl;

    localparam logic [7:0] EXP = 8'h75;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start1, start0;
    logic [7:0] func_tbl;

    logic [2:0] sop_in1, sop_in0;
    logic       sop_out1, sop_out0;
    logic       busy1, busy0, done1, done0, pass1, pass0;
    logic [7:0] result1, result0;
    logic [3:0] mc1, mc0;

    bit         use_s0;
    logic [2:0] obs_sop_in;
    logic       obs_busy, obs_done, obs_pass;
    logic [7:0] obs_result;
    logic [3:0] obs_mc;

    int n_checks = 0;
    int n_fail   = 0;

    int trace_q[$];
    int done_pulses;
    int lat;
    bit overlap;
    bit late_busy;

    // Function under sweep: a lookup table the bench can corrupt at will.
    assign sop_out1 = func_tbl[sop_in1];
    assign sop_out0 = func_tbl[sop_in0];

    assign obs_sop_in = use_s0 ? sop_in0 : sop_in1;
    assign obs_busy   = use_s0 ? busy0   : busy1;
    assign obs_done   = use_s0 ? done0   : done1;
    assign obs_result = use_s0 ? result0 : result1;
    assign obs_pass   = use_s0 ? pass0   : pass1;
    assign obs_mc     = use_s0 ? mc0     : mc1;

    sop_sweep_ctrl #(.EXPECTED(EXP), .SETTLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .sop_in(sop_in1),
        .sop_out(sop_out1), .busy(busy1), .done(done1), .result(result1),
        .pass(pass1), .mismatch_count(mc1)
    );

    sop_sweep_ctrl #(.EXPECTED(EXP), .SETTLE(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .sop_in(sop_in0),
        .sop_out(sop_out0), .busy(busy0), .done(done0), .result(result0),
        .pass(pass0), .mismatch_count(mc0)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic int settle_of();
        return use_s0 ? 0 : 1;
    endfunction

    task automatic set_start(input bit v);
        if (use_s0) start0 = v;
        else        start1 = v;
    endtask

    // Pulse start, then watch the selected DUT for ncyc falling edges.
    task automatic run_sweep(input int restart_at, input bit restart_in_done, input int ncyc);
        trace_q.delete();
        done_pulses = 0;
        lat         = -1;
        overlap     = 0;
        late_busy   = 0;
        @(negedge clk);
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        for (int n = 1; n <= ncyc; n++) begin
            if (obs_busy && obs_done) overlap = 1;
            if (obs_busy) begin
                if (lat >= 0) late_busy = 1;
                else          trace_q.push_back(int'(obs_sop_in));
            end
            if (obs_done) begin
                done_pulses++;
                if (lat < 0) lat = n - 1;
            end
            set_start((n == restart_at) || (restart_in_done && obs_done));
            @(negedge clk);
        end
        set_start(1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start1 = 1'b0; start0 = 1'b0; func_tbl = EXP; use_s0 = 0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({sop_in1, busy1, done1, result1, pass1, mc1} !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_s1: got %h expected 0", {sop_in1, busy1, done1, result1, pass1, mc1});
        end
        n_checks++;
        if ({sop_in0, busy0, done0, result0, pass0, mc0} !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_s0: got %h expected 0", {sop_in0, busy0, done0, result0, pass0, mc0});
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({sop_in1, busy1, done1, result1, pass1, mc1, sop_in0, busy0, done0, result0, pass0, mc0} !== 36'h0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %h expected 0",
                     {sop_in1, busy1, done1, result1, pass1, mc1, sop_in0, busy0, done0, result0, pass0, mc0});
        end
    endtask

    // Full sweep with a given function table; all expectations from the table.
    task automatic test_sweep(input string name, input bit s0, input logic [7:0] tbl);
        int  s;
        int  bad_at;
        logic [3:0] exp_mc;
        use_s0   = s0;
        func_tbl = tbl;
        s        = settle_of();
        run_sweep(0, 0, 8 * (s + 1) + 5);
        bad_at = -1;
        if (trace_q.size() != 8 * (s + 1)) bad_at = trace_q.size();
        else
            for (int k = 0; k < trace_q.size(); k++)
                if (bad_at < 0 && trace_q[k] != k / (s + 1)) bad_at = k;
        n_checks++;
        if (bad_at >= 0) begin
            n_fail++;
            $display("FAIL %s_trace: got %0d busy cycles, first bad at %0d, expected %0d cycles of steps 0..7",
                     name, trace_q.size(), bad_at, 8 * (s + 1));
        end
        n_checks++;
        if (lat !== 8 * (s + 1) || done_pulses !== 1) begin
            n_fail++;
            $display("FAIL %s_latency: got lat %0d pulses %0d expected lat %0d pulses 1",
                     name, lat, done_pulses, 8 * (s + 1));
        end
        n_checks++;
        if (overlap || late_busy) begin
            n_fail++;
            $display("FAIL %s_busy: got overlap %0d late %0d expected 0 0", name, overlap, late_busy);
        end
        exp_mc = 4'($countones(tbl ^ EXP));
        n_checks++;
        if ({obs_result, obs_pass, obs_mc} !== {tbl, (tbl == EXP), exp_mc}) begin
            n_fail++;
            $display("FAIL %s_result: got res %h pass %0d mc %0d expected res %h pass %0d mc %0d",
                     name, obs_result, obs_pass, obs_mc, tbl, (tbl == EXP), exp_mc);
        end
    endtask

    task automatic test_functions();
        test_sweep("good_s1",   0, EXP);
        test_sweep("f7_s1",     0, 8'hF5);
        test_sweep("stuck0_s1", 0, 8'h00);
        test_sweep("good_s0",   1, EXP);
        test_sweep("stuck1_s0", 1, 8'hFF);
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            test_sweep("rand", 1'($urandom_range(0, 1)), 8'($urandom));
        end
    endtask

    task automatic test_start_ignored();
        int bad_at;
        use_s0   = 0;
        func_tbl = EXP;
        run_sweep(5, 1, 22);
        bad_at = (trace_q.size() != 16) ? 99 : -1;
        for (int k = 0; k < trace_q.size() && k < 16; k++)
            if (bad_at < 0 && trace_q[k] != k / 2) bad_at = k;
        n_checks++;
        if (bad_at >= 0 || done_pulses !== 1 || late_busy) begin
            n_fail++;
            $display("FAIL start_ignored: got size %0d bad %0d pulses %0d late %0d expected 16 -1 1 0",
                     trace_q.size(), bad_at, done_pulses, late_busy);
        end
        n_checks++;
        if (obs_result !== EXP) begin
            n_fail++;
            $display("FAIL start_ignored_result: got %h expected %h", obs_result, EXP);
        end
    endtask

    task automatic test_back_to_back();
        bit b_arr[64];
        bit d_arr[64];
        int d_idx[$];
        use_s0   = 0;
        func_tbl = EXP;
        @(negedge clk);
        set_start(1'b1);
        for (int n = 1; n < 64; n++) begin
            @(negedge clk);
            b_arr[n] = obs_busy;
            d_arr[n] = obs_done;
            if (obs_done) d_idx.push_back(n);
        end
        set_start(1'b0);
        n_checks++;
        if (d_idx.size() < 3 || d_idx[1] - d_idx[0] != 18 || d_idx[2] - d_idx[1] != 18) begin
            n_fail++;
            $display("FAIL b2b_period: got %0d pulses first gap %0d expected >=3 pulses gap 18",
                     d_idx.size(), (d_idx.size() > 1) ? d_idx[1] - d_idx[0] : -1);
        end
        if (d_idx.size() > 0 && d_idx[0] < 60) begin
            n_checks++;
            if ({b_arr[d_idx[0] + 1], d_arr[d_idx[0] + 1], b_arr[d_idx[0] + 2]} !== 3'b001) begin
                n_fail++;
                $display("FAIL b2b_idle_gap: got busy/done/busy %b expected 001",
                         {b_arr[d_idx[0] + 1], d_arr[d_idx[0] + 1], b_arr[d_idx[0] + 2]});
            end
        end
        repeat (25) @(negedge clk);
    endtask

    task automatic test_async_reset();
        bit seen;
        bit saw_done;
        use_s0   = 0;
        func_tbl = EXP;
        @(negedge clk);
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        seen = 0;
        for (int n = 0; n < 40 && !seen; n++) begin
            if (obs_sop_in == 3'd3) seen = 1;
            else @(negedge clk);
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL areset_reach3: got timeout expected sop_in 3");
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({obs_sop_in, obs_busy, obs_done, obs_result, obs_pass, obs_mc} !== 18'h0) begin
            n_fail++;
            $display("FAIL areset_clear: got %h expected 0",
                     {obs_sop_in, obs_busy, obs_done, obs_result, obs_pass, obs_mc});
        end
        saw_done = 0;
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            if (n == 3) rst_n = 1'b1;
            if (obs_done || obs_busy) saw_done = 1;
        end
        n_checks++;
        if (saw_done) begin
            n_fail++;
            $display("FAIL areset_no_done: got activity 1 expected 0");
        end
        test_sweep("after_reset", 0, EXP);
    endtask

    task automatic test_persistence();
        logic [7:0] tbls [2];
        logic [7:0] r0;
        logic       p0;
        logic [3:0] m0;
        bit         changed;
        tbls[0] = EXP;
        tbls[1] = 8'hF5;
        use_s0  = 0;
        for (int t = 0; t < 2; t++) begin
            func_tbl = tbls[t];
            run_sweep(0, 0, 21);
            r0 = obs_result; p0 = obs_pass; m0 = obs_mc;
            changed = 0;
            repeat (20) begin
                @(negedge clk);
                if ({obs_result, obs_pass, obs_mc} !== {r0, p0, m0}) changed = 1;
            end
            n_checks++;
            if (changed || r0 !== tbls[t]) begin
                n_fail++;
                $display("FAIL persist_hold: got res %h changed %0d expected %h held", r0, changed, tbls[t]);
            end
            set_start(1'b1);
            @(negedge clk);
            set_start(1'b0);
            n_checks++;
            if ({obs_result, obs_pass, obs_mc, obs_busy, obs_sop_in} !== {8'h00, 1'b0, 4'h0, 1'b1, 3'd0}) begin
                n_fail++;
                $display("FAIL persist_clear: got res %h pass %0d mc %0d busy %0d sop_in %0d expected 0 0 0 1 0",
                         obs_result, obs_pass, obs_mc, obs_busy, obs_sop_in);
            end
            repeat (20) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_functions();
        test_random();
        test_start_ignored();
        test_back_to_back();
        test_async_reset();
        test_persistence();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
